chan_scan_mux: RTL and testbench
================================

Name: chan_scan_mux

Overview:
- Parametrised N-channel, W-bit selector with a registered output stage and valid/ready handshake on the output side.
- Two modes: manual (host-loaded channel pointer) and scan (pointer auto-advances after a programmable number of output transfers).
- Sits between the register-file/pipeline-stage debug taps and the display/UART debug path. Replaces fixed 16:1 combinational selection.

Parameters:
- WIDTH, 32, data bits per channel.
- NCH, 16, channel count, 2..64; need not be a power of two.
- SELW, $clog2(NCH), pointer width (derived; do not override).
- DWELL, 4, output transfers per channel in scan mode, >=1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = manual, 1 = scan.
- sel_ld  in  1  one-cycle pulse; load sel_in into the pointer.
- sel_in  in  SELW  channel to load.
- din  in  NCH*WIDTH  flattened channels; channel k occupies din[k*WIDTH +: WIDTH].
- o_valid  out  1  output data valid.
- o_ready  in  1  consumer accepts when high together with o_valid.
- o_data  out  WIDTH  registered selected channel.
- o_sel  out  SELW  channel index that produced o_data.
- sel_err  out  1  one-cycle pulse: sel_ld carried an out-of-range index.

Behaviour:
- Reset (async assert, sync release): ptr=0, dwell_cnt=0, o_valid=0, o_data=0, o_sel=0, sel_err=0.
- Output register loads when (!o_valid || o_ready). It loads o_data=din[ptr], o_sel=ptr, o_valid=1.
  - Latency is one cycle from a pointer change to o_data.
  - First valid output appears on the second rising edge after reset release.
- While o_valid && !o_ready, o_data and o_sel hold stable even if din changes. Required by the handshake.
- Transfer = o_valid && o_ready at a rising edge.
- Pointer FSM states:
  - MAN: ptr changes only on sel_ld.
  - SCAN: each transfer increments dwell_cnt. When dwell_cnt==DWELL-1 on a transfer:
    - dwell_cnt returns to 0;
    - ptr advances to the next enabled channel;
    - NCH-1 wraps to 0.
- Transitions:
  - mode 0->1 enters SCAN with dwell_cnt=0.
  - mode 1->0 enters MAN, freezing ptr.
- sel_ld behaviour:
  - Valid in either mode. It has priority over the scan advance in the same cycle.
  - It also clears dwell_cnt.
  - If sel_in >= NCH: ptr unchanged, sel_err=1 for exactly one cycle.
- Pointer updates never alter an already-valid held output. The new channel appears only at the next output load.
- Reset asserted mid-operation clears all state immediately. A pending held output is discarded.

Optional Feature:
- Macro CHAN_SCAN_MUX_MASK_EN.
- With the macro: extra input ch_mask [NCH], where 1 = channel enabled.
  - The scan advance skips disabled channels, searching upward with wrap.
  - If no channel is enabled, ptr holds and scanning stalls; output still tracks din[ptr].
  - A manual sel_ld to a disabled channel is accepted (the mask affects scan only).
- Without the macro: no port; every channel is enabled.

Decomposition:
- Package chan_scan_mux_pkg: mode encoding (MODE_MAN=0, MODE_SCAN=1), FSM state typedef, and a helper function for the next-enabled-index search.
- One sub-module is natural: chan_scan_ptr (pointer FSM, dwell counter, sel_err, mask search).
- The top holds the wide select and the output register.

Test Plan:
- Manual select: mode=0, din channel k = 32'hA000_0000+k, o_ready=1, sel_ld with sel_in=5 -> next load gives o_data=32'hA000_0005, o_sel=5; holds indefinitely.
- Scan wrap: DWELL=2, NCH=16, mode=1, o_ready=1 -> o_sel sequence 0,0,1,1,…,15,15,0,0.
- Backpressure: o_ready=0 for 10 cycles while din[ptr] toggles -> o_data/o_sel stable; no dwell progress. On release, exactly one transfer of the held value.
- Out-of-range: NCH=12, sel_in=13 with sel_ld -> sel_err high one cycle, o_sel unchanged. Same-cycle sel_ld and scan advance -> sel_in wins, dwell_cnt=0.
- Reset mid-scan: assert rst_n=0 asynchronously at ptr=7 -> all outputs zero without a clock edge. After release, scan restarts at channel 0.
- Mask (macro on): ch_mask=16'h0505, DWELL=1 -> o_sel cycles 0,2,8,10,0. ch_mask=0 -> ptr frozen.

Source files
------------

// File: rtl/chan_scan_mux_pkg.sv
// Shared types and helpers for the chan_scan_mux debug-tap selector.
package chan_scan_mux_pkg;

    localparam logic MODE_MAN  = 1'b0;
    localparam logic MODE_SCAN = 1'b1;
    localparam int   MAX_NCH   = 64;

    typedef enum logic {ST_MAN, ST_SCAN} ptr_state_t;

    // Next enabled channel strictly above cur, wrapping; returns cur when nothing else is enabled.
    function automatic int next_enabled(input int cur, input logic [MAX_NCH-1:0] mask, input int nch);
        int   res;
        logic found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= MAX_NCH; i++) begin
            int idx;
            idx = cur + i;
            if (idx >= nch) idx = idx - nch;
            if (!found && i <= nch && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/chan_scan_ptr.sv
// Channel pointer FSM: manual load, dwell-counted scan advance, range error pulse.
module chan_scan_ptr
    import chan_scan_mux_pkg::*;
#(
    parameter int NCH   = 16,
    parameter int DWELL = 4,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic            sel_ld,
    input  logic [SELW-1:0] sel_in,
    input  logic            xfer,
    input  logic [NCH-1:0]  mask,
    output logic [SELW-1:0] ptr,
    output logic            sel_err
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);

    ptr_state_t           state_q, state_d;
    logic [DW-1:0]        dwell_q, dwell_d;
    logic [SELW-1:0]      ptr_d, ptr_adv;
    logic                 err_d, in_range;
    logic [MAX_NCH-1:0]   mask_ext;

    assign mask_ext = MAX_NCH'(mask);
    assign ptr_adv  = SELW'(next_enabled(int'(ptr), mask_ext, NCH));
    assign in_range = {1'b0, sel_in} < (SELW+1)'(NCH);

    // A manual load outranks the scan advance and restarts the dwell window.
    always_comb begin
        state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_MAN;
        ptr_d   = ptr;
        dwell_d = dwell_q;
        err_d   = 1'b0;
        if (sel_ld) begin
            dwell_d = '0;
            if (in_range) ptr_d = sel_in;
            else          err_d = 1'b1;
        end else if (state_d == ST_SCAN) begin
            if (state_q == ST_MAN) begin
                dwell_d = '0;
            end else if (xfer) begin
                if (dwell_q == DLAST) begin
                    dwell_d = '0;
                    ptr_d   = ptr_adv;
                end else begin
                    dwell_d = DW'(dwell_q + 1'b1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_MAN;
            dwell_q <= '0;
            ptr     <= '0;
            sel_err <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            ptr     <= ptr_d;
            sel_err <= err_d;
        end
    end

endmodule

// File: rtl/chan_scan_mux.sv
// N-channel selector with registered valid/ready output and manual/scan pointer.
// Optional CHAN_SCAN_MUX_MASK_EN adds ch_mask to skip disabled channels while scanning.
module chan_scan_mux
    import chan_scan_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NCH   = 16,
    parameter int SELW  = $clog2(NCH),
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic                 sel_ld,
    input  logic [SELW-1:0]      sel_in,
    input  logic [NCH*WIDTH-1:0] din,
`ifdef CHAN_SCAN_MUX_MASK_EN
    input  logic [NCH-1:0]       ch_mask,
`endif
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [WIDTH-1:0]     o_data,
    output logic [SELW-1:0]      o_sel,
    output logic                 sel_err
);

    logic [WIDTH-1:0] ch [NCH];
    logic [NCH-1:0]   mask;
    logic [SELW-1:0]  ptr;
    logic             run_q, xfer, load;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign ch[k] = din[k*WIDTH +: WIDTH];
    end

`ifdef CHAN_SCAN_MUX_MASK_EN
    assign mask = ch_mask;
`else
    assign mask = '1;
`endif

    assign xfer = o_valid && o_ready;
    // run_q delays the first load so valid data appears on the second edge after reset.
    assign load = run_q && (!o_valid || o_ready);

    chan_scan_ptr #(.NCH(NCH), .DWELL(DWELL), .SELW(SELW)) u_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode),
        .sel_ld  (sel_ld),
        .sel_in  (sel_in),
        .xfer    (xfer),
        .mask    (mask),
        .ptr     (ptr),
        .sel_err (sel_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sel   <= '0;
        end else begin
            run_q <= 1'b1;
            if (load) begin
                o_valid <= 1'b1;
                o_data  <= ch[ptr];
                o_sel   <= ptr;
            end
        end
    end

endmodule

// File: tb/tb_chan_scan_mux.sv
// Randomized bench for chan_scan_mux against a cycle-level reference model.
module tb_chan_scan_mux;

    localparam int WIDTH = 32;
    localparam int NCH   = 12;
    localparam int DWELL = 2;
    localparam int SELW  = $clog2(NCH);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 mode, sel_ld, o_ready;
    logic [SELW-1:0]      sel_in;
    logic [NCH*WIDTH-1:0] din;
    logic [NCH-1:0]       ch_mask;
    logic                 o_valid, sel_err;
    logic [WIDTH-1:0]     o_data;
    logic [SELW-1:0]      o_sel;

    int checks = 0;
    int errors = 0;

    // reference state
    int         m_ptr, m_dwell, m_sel;
    bit         m_prev_scan, m_run, m_valid, m_err;
    logic [WIDTH-1:0] m_data;

    always #5 clk = ~clk;

    chan_scan_mux #(.WIDTH(WIDTH), .NCH(NCH), .DWELL(DWELL)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode),
        .sel_ld  (sel_ld),
        .sel_in  (sel_in),
        .din     (din),
`ifdef CHAN_SCAN_MUX_MASK_EN
        .ch_mask (ch_mask),
`endif
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_sel   (o_sel),
        .sel_err (sel_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NCH-1:0] eff_mask();
`ifdef CHAN_SCAN_MUX_MASK_EN
        return ch_mask;
`else
        return '1;
`endif
    endfunction

    function automatic int next_en(input int cur);
        logic [NCH-1:0] mk;
        mk = eff_mask();
        for (int i = 1; i <= NCH; i++)
            if (mk[(cur + i) % NCH]) return (cur + i) % NCH;
        return cur;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_dwell = 0; m_prev_scan = 0; m_run = 0;
        m_valid = 0; m_data = '0; m_sel = 0; m_err = 0;
    endtask

    // One rising edge of the reference, using inputs held across the edge.
    task automatic model_step();
        bit xfer, load;
        int ptr0;
        xfer = m_valid && o_ready;
        load = m_run && (!m_valid || o_ready);
        ptr0 = m_ptr;
        if (load) begin
            m_valid = 1;
            m_data  = din[ptr0*WIDTH +: WIDTH];
            m_sel   = ptr0;
        end
        m_err = sel_ld && (int'(sel_in) >= NCH);
        if (sel_ld) begin
            m_dwell = 0;
            if (int'(sel_in) < NCH) m_ptr = int'(sel_in);
        end else if (mode) begin
            if (!m_prev_scan) m_dwell = 0;
            else if (xfer) begin
                if (m_dwell == DWELL - 1) begin
                    m_dwell = 0;
                    m_ptr   = next_en(ptr0);
                end else m_dwell++;
            end
        end
        m_prev_scan = mode;
        m_run = 1;
    endtask

    task automatic compare(input string tag);
        chk({tag, ".valid"}, 64'(o_valid), 64'(m_valid));
        chk({tag, ".data"},  64'(o_data),  64'(m_data));
        chk({tag, ".sel"},   64'(o_sel),   64'(m_sel));
        chk({tag, ".err"},   64'(sel_err), 64'(m_err));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare(tag);
    endtask

    task automatic rand_din();
        for (int k = 0; k < NCH; k++) din[k*WIDTH +: WIDTH] = $urandom;
    endtask

    task automatic zero_check(input string tag);
        chk({tag, ".valid"}, 64'(o_valid), 64'd0);
        chk({tag, ".data"},  64'(o_data),  64'd0);
        chk({tag, ".sel"},   64'(o_sel),   64'd0);
        chk({tag, ".err"},   64'(sel_err), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; mode = 0; sel_ld = 0; sel_in = '0; o_ready = 1; din = '0;
        ch_mask = '1;
        model_reset();
        #12;
        zero_check("reset");
        rst_n = 1'b1;

        // manual select of channel 5 with a fixed data pattern
        for (int k = 0; k < NCH; k++) din[k*WIDTH +: WIDTH] = 32'hA000_0000 + k;
        step("man_first");
        chk("man_first_valid_late", 64'(o_valid), 64'd0);
        sel_ld = 1; sel_in = 5;
        step("man_ld");
        sel_ld = 0;
        for (int i = 0; i < 5; i++) step("man_hold");
        chk("man_data5", 64'(o_data), 64'hA000_0005);
        chk("man_sel5",  64'(o_sel),  64'd5);

        // out-of-range load: error pulse, pointer unchanged
        sel_ld = 1; sel_in = 13;
        step("oor");
        chk("oor_err", 64'(sel_err), 64'd1);
        sel_ld = 0;
        step("oor_after");
        chk("oor_err_clr", 64'(sel_err), 64'd0);
        step("oor_after2");
        chk("oor_sel_kept", 64'(o_sel), 64'd5);

        // full scan sweep with ready held high, covering wrap
        mode = 1; sel_ld = 1; sel_in = 0;
        step("scan_ld");
        sel_ld = 0;
        for (int i = 0; i < 2*DWELL*NCH + 6; i++) begin
            rand_din();
            step("scan");
        end

        // backpressure: held output stays stable while din toggles
        o_ready = 0;
        step("bp_enter");
        for (int i = 0; i < 10; i++) begin
            logic [WIDTH-1:0] hd;
            logic [SELW-1:0]  hs;
            hd = o_data; hs = o_sel;
            rand_din();
            step("bp");
            chk("bp_data_stable", 64'(o_data), 64'(hd));
            chk("bp_sel_stable",  64'(o_sel),  64'(hs));
        end
        o_ready = 1;

        // randomized mix of modes, loads, backpressure
        for (int i = 0; i < 600; i++) begin
            rand_din();
            o_ready = ($urandom_range(0, 3) != 0);
            sel_ld  = ($urandom_range(0, 9) == 0);
            sel_in  = SELW'($urandom_range(0, (1 << SELW) - 1));
            if ($urandom_range(0, 29) == 0) mode = ~mode;
`ifdef CHAN_SCAN_MUX_MASK_EN
            if ($urandom_range(0, 39) == 0)
                case ($urandom_range(0, 3))
                    0: ch_mask = 12'h505;
                    1: ch_mask = '0;
                    2: ch_mask = '1;
                    default: ch_mask = NCH'($urandom);
                endcase
`endif
            step("rand");
        end

        // asynchronous reset mid-scan, then restart from channel 0
        mode = 1; sel_ld = 1; sel_in = 7; o_ready = 1;
        step("pre_rst");
        sel_ld = 0;
        step("pre_rst2");
        #2 rst_n = 1'b0;
        #1;
        zero_check("async_rst");
        model_reset();
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4*DWELL + 4; i++) begin
            rand_din();
            step("post_rst");
        end

`ifdef CHAN_SCAN_MUX_MASK_EN
        ch_mask = 12'h505; mode = 1; o_ready = 1;
        for (int i = 0; i < 40; i++) begin
            rand_din();
            step("mask");
        end
        ch_mask = '0;
        for (int i = 0; i < 20; i++) step("mask_none");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
